multi_channel_threshold_comparator: RTL and testbench

- Registered, parametrised successor to the single-pair unsigned `a_gteq_b` / `a_lt_b` comparator.
- Compares CHANNELS unsigned samples against a shared, runtime-loadable high/low threshold pair.
- Applies hysteresis plus a consecutive-sample persistence filter per channel.
- Sits between the sampled detector/counter data path and the POP timing sequencer; emits per-channel level state and one-cycle rise/fall event pulses.

---
 rtl/multi_channel_threshold_comparator_if.sv | 29 ++
 rtl/multi_channel_threshold_comparator.sv | 143 ++++++++++++++
 tb/tb_multi_channel_threshold_comparator.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_channel_threshold_comparator_if.sv
// Sample/threshold bus between the detector data path and the threshold comparator.
// The master drives samples and threshold loads; the slave returns levels and event pulses.
interface multi_channel_threshold_comparator_if #(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 4
);
   logic                      sample_valid;
   logic [CHANNELS*WIDTH-1:0] sample;
   logic                      thr_load;
   logic [WIDTH-1:0]          thr_hi_in;
   logic [WIDTH-1:0]          thr_lo_in;
   logic [CHANNELS-1:0]       a_gteq_b;
   logic [CHANNELS-1:0]       a_lt_b;
   logic [CHANNELS-1:0]       rise;
   logic [CHANNELS-1:0]       fall;
   logic                      out_valid;
   logic [WIDTH-1:0]          thr_hi;
   logic [WIDTH-1:0]          thr_lo;

   modport master (
      output sample_valid, sample, thr_load, thr_hi_in, thr_lo_in,
      input  a_gteq_b, a_lt_b, rise, fall, out_valid, thr_hi, thr_lo
   );

   modport slave (
      input  sample_valid, sample, thr_load, thr_hi_in, thr_lo_in,
      output a_gteq_b, a_lt_b, rise, fall, out_valid, thr_hi, thr_lo
   );
endinterface

// File: rtl/multi_channel_threshold_comparator.sv
// Per-channel hysteresis comparator with a consecutive-sample persistence filter,
// sharing one runtime-loadable high/low threshold pair across all channels.

module mctc_channel #(
   parameter int WIDTH = 16,
   parameter int HOLD  = 3
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             sample_valid_i,
   input  logic [WIDTH-1:0] sample_i,
   input  logic [WIDTH-1:0] thr_hi_i,
   input  logic [WIDTH-1:0] thr_lo_i,
   output logic             level_o,
   output logic             rise_o,
   output logic             fall_o
);
   localparam int            CW   = $clog2(HOLD + 1);
   localparam logic [CW-1:0] LAST = CW'(HOLD - 1);

   typedef enum logic {ST_LOW = 1'b0, ST_HIGH = 1'b1} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          rise_q, rise_d;
   logic          fall_q, fall_d;
   logic          qualify;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_LOW;
         cnt_q   <= '0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   // A run only counts strictly consecutive valid samples; invalid cycles freeze it.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      qualify = (state_q == ST_LOW) ? (sample_i >= thr_hi_i) : (sample_i < thr_lo_i);
      if (sample_valid_i) begin
         if (!qualify) begin
            cnt_d = '0;
         end else if (cnt_q == LAST) begin
            cnt_d = '0;
            case (state_q)
               ST_LOW: begin
                  state_d = ST_HIGH;
                  rise_d  = 1'b1;
               end
               default: begin
                  state_d = ST_LOW;
                  fall_d  = 1'b1;
               end
            endcase
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   assign level_o = (state_q == ST_HIGH);
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;
endmodule

module multi_channel_threshold_comparator #(
   parameter int WIDTH      = 16,
   parameter int CHANNELS   = 4,
   parameter int HOLD       = 3,
   parameter int THR_HI_RST = 12,
   parameter int THR_LO_RST = 10
) (
   input logic clock,
   input logic reset_n,
   multi_channel_threshold_comparator_if.slave bus
);
   localparam logic [WIDTH-1:0] THR_HI_INIT = WIDTH'(THR_HI_RST);
   localparam logic [WIDTH-1:0] THR_LO_INIT =
      WIDTH'((THR_LO_RST > THR_HI_RST) ? THR_HI_RST : THR_LO_RST);

   logic [WIDTH-1:0]    thr_hi_q, thr_hi_d;
   logic [WIDTH-1:0]    thr_lo_q, thr_lo_d;
   logic                out_valid_q;
   logic [CHANNELS-1:0] level, rise, fall;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         thr_hi_q    <= THR_HI_INIT;
         thr_lo_q    <= THR_LO_INIT;
         out_valid_q <= 1'b0;
      end else begin
         thr_hi_q    <= thr_hi_d;
         thr_lo_q    <= thr_lo_d;
         out_valid_q <= bus.sample_valid;
      end
   end

   // Low threshold is clamped to the high one so the band can collapse but never invert.
   always_comb begin
      thr_hi_d = thr_hi_q;
      thr_lo_d = thr_lo_q;
      if (bus.thr_load) begin
         thr_hi_d = bus.thr_hi_in;
         thr_lo_d = (bus.thr_lo_in > bus.thr_hi_in) ? bus.thr_hi_in : bus.thr_lo_in;
      end
   end

   // Channels see the registered thresholds, so a same-cycle load affects only later samples.
   for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      mctc_channel #(
         .WIDTH (WIDTH),
         .HOLD  (HOLD)
      ) u_ch (
         .clock          (clock),
         .reset_n        (reset_n),
         .sample_valid_i (bus.sample_valid),
         .sample_i       (bus.sample[k*WIDTH +: WIDTH]),
         .thr_hi_i       (thr_hi_q),
         .thr_lo_i       (thr_lo_q),
         .level_o        (level[k]),
         .rise_o         (rise[k]),
         .fall_o         (fall[k])
      );
   end

   assign bus.a_gteq_b  = level;
   assign bus.a_lt_b    = ~level;
   assign bus.rise      = rise;
   assign bus.fall      = fall;
   assign bus.out_valid = out_valid_q;
   assign bus.thr_hi    = thr_hi_q;
   assign bus.thr_lo    = thr_lo_q;
endmodule

// File: tb/tb_multi_channel_threshold_comparator.sv
// Bench for multi_channel_threshold_comparator: directed scenarios plus a randomized
// run checked against a run-length/threshold reference model.
module tb_multi_channel_threshold_comparator;
   localparam int W    = 16;
   localparam int CH   = 4;
   localparam int HOLD = 3;

   logic clock   = 1'b0;
   logic reset_n = 1'b1;

   multi_channel_threshold_comparator_if #(.WIDTH(W), .CHANNELS(CH)) bus ();

   multi_channel_threshold_comparator #(
      .WIDTH      (W),
      .CHANNELS   (CH),
      .HOLD       (HOLD),
      .THR_HI_RST (12),
      .THR_LO_RST (10)
   ) u_dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   int          m_state [CH];
   int          m_run   [CH];
   int          m_hi, m_lo;
   logic [CH-1:0] m_rise, m_fall;
   logic        m_ov;

   function automatic logic [CH*W-1:0] smp(input int c0, input int c1, input int c2, input int c3);
      logic [CH*W-1:0] v;
      v[0*W +: W] = W'(c0);
      v[1*W +: W] = W'(c1);
      v[2*W +: W] = W'(c2);
      v[3*W +: W] = W'(c3);
      return v;
   endfunction

   function automatic logic [CH-1:0] m_level();
      logic [CH-1:0] l;
      for (int k = 0; k < CH; k++) l[k] = (m_state[k] != 0);
      return l;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < CH; k++) begin
         m_state[k] = 0;
         m_run[k]   = 0;
      end
      m_hi = 12; m_lo = 10;
      m_rise = '0; m_fall = '0; m_ov = 1'b0;
   endtask

   // Drive one input cycle, advance the model at the edge, leave outputs sampled #1 later.
   task automatic cycle(input logic v, input logic [CH*W-1:0] s,
                        input logic ld = 1'b0, input int hi = 0, input int lo = 0);
      int x;
      bit q;
      bus.sample_valid = v;
      bus.sample       = s;
      bus.thr_load     = ld;
      bus.thr_hi_in    = W'(hi);
      bus.thr_lo_in    = W'(lo);
      @(posedge clock);
      m_ov = v; m_rise = '0; m_fall = '0;
      if (v) begin
         for (int k = 0; k < CH; k++) begin
            x = int'(s[k*W +: W]);
            q = (m_state[k] != 0) ? (x < m_lo) : (x >= m_hi);
            if (q) begin
               m_run[k]++;
               if (m_run[k] == HOLD) begin
                  m_run[k]   = 0;
                  m_state[k] = 1 - m_state[k];
                  if (m_state[k] != 0) m_rise[k] = 1'b1;
                  else                 m_fall[k] = 1'b1;
               end
            end else begin
               m_run[k] = 0;
            end
         end
      end
      if (ld) begin
         m_hi = hi;
         m_lo = (lo > hi) ? hi : lo;
      end
      #1;
      bus.sample_valid = 1'b0;
      bus.thr_load     = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      model_reset();
      @(posedge clock);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      #1 reset_n = 1'b0;
      #1;
      n_checks++; if (bus.a_gteq_b !== 4'h0) begin n_fail++; $display("FAIL reset_a_gteq_b: got %h want 0", bus.a_gteq_b); end
      n_checks++; if (bus.a_lt_b !== 4'hF) begin n_fail++; $display("FAIL reset_a_lt_b: got %h want f", bus.a_lt_b); end
      n_checks++; if (bus.thr_hi !== 16'd12) begin n_fail++; $display("FAIL reset_thr_hi: got %0d want 12", bus.thr_hi); end
      n_checks++; if (bus.thr_lo !== 16'd10) begin n_fail++; $display("FAIL reset_thr_lo: got %0d want 10", bus.thr_lo); end
      n_checks++; if (bus.rise !== 4'h0 || bus.fall !== 4'h0) begin n_fail++; $display("FAIL reset_pulses: got rise %h fall %h want 0 0", bus.rise, bus.fall); end
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
      model_reset();
      @(posedge clock);
      @(posedge clock);
      #1 reset_n = 1'b1;
   endtask

   task automatic test_persistence();
      logic [CH-1:0] exp_r [3] = '{4'b0000, 4'b0000, 4'b0001};
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, smp(15, 0, 0, 0));
         n_checks++; if (bus.rise !== exp_r[i]) begin n_fail++; $display("FAIL persist_rise%0d: got %b want %b", i, bus.rise, exp_r[i]); end
      end
      n_checks++; if (bus.a_gteq_b !== 4'b0001) begin n_fail++; $display("FAIL persist_level: got %b want 0001", bus.a_gteq_b); end
      cycle(1'b0, smp(0, 0, 0, 0));
      n_checks++; if (bus.rise !== 4'b0000 || bus.a_gteq_b !== 4'b0001) begin n_fail++; $display("FAIL persist_after: got rise %b lvl %b want 0000 0001", bus.rise, bus.a_gteq_b); end
      // broken run on ch2: 15,15,11,15
      cycle(1'b1, smp(15, 0, 15, 0));
      cycle(1'b1, smp(15, 0, 15, 0));
      cycle(1'b1, smp(15, 0, 11, 0));
      cycle(1'b1, smp(15, 0, 15, 0));
      n_checks++; if (bus.rise !== 4'b0000 || bus.a_gteq_b !== 4'b0001) begin n_fail++; $display("FAIL persist_broken: got rise %b lvl %b want 0000 0001", bus.rise, bus.a_gteq_b); end
   endtask

   task automatic test_hysteresis();
      for (int i = 0; i < 3; i++) cycle(1'b1, smp(15, 15, 0, 0));
      n_checks++; if (bus.rise !== 4'b0010 || bus.a_gteq_b !== 4'b0011) begin n_fail++; $display("FAIL hyst_enter: got rise %b lvl %b want 0010 0011", bus.rise, bus.a_gteq_b); end
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, smp(15, 11, 0, 0));
         n_checks++; if (bus.fall !== 4'b0000) begin n_fail++; $display("FAIL hyst_band%0d: got fall %b want 0000", i, bus.fall); end
      end
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, smp(15, 9, 0, 0));
         n_checks++; if (bus.fall !== ((i == 2) ? 4'b0010 : 4'b0000)) begin n_fail++; $display("FAIL hyst_fall%0d: got fall %b", i, bus.fall); end
      end
      n_checks++; if (bus.a_lt_b !== 4'b1110) begin n_fail++; $display("FAIL hyst_a_lt_b: got %b want 1110", bus.a_lt_b); end
      // exactly thr_lo in HIGH and thr_hi-1 in LOW never qualify
      for (int i = 0; i < 3; i++) cycle(1'b1, smp(10, 0, 11, 0));
      n_checks++; if (bus.rise !== 4'b0000 || bus.fall !== 4'b0000 || bus.a_gteq_b !== 4'b0001) begin n_fail++; $display("FAIL hyst_edges: got rise %b fall %b lvl %b", bus.rise, bus.fall, bus.a_gteq_b); end
      for (int i = 0; i < 3; i++) cycle(1'b1, smp(10, 0, 12, 0));
      n_checks++; if (bus.rise !== 4'b0100 || bus.a_gteq_b !== 4'b0101) begin n_fail++; $display("FAIL hyst_hi_exact: got rise %b lvl %b want 0100 0101", bus.rise, bus.a_gteq_b); end
   endtask

   task automatic test_gaps();
      int ov_cnt = 0;
      cycle(1'b1, smp(15, 0, 0, 0));
      if (bus.out_valid === 1'b1) ov_cnt++;
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, smp(0, 0, 0, 0));
         if (bus.out_valid === 1'b1) ov_cnt++;
         n_checks++; if (bus.rise !== 4'b0000) begin n_fail++; $display("FAIL gap_rise%0d: got %b want 0000", i, bus.rise); end
      end
      cycle(1'b1, smp(15, 0, 0, 0));
      if (bus.out_valid === 1'b1) ov_cnt++;
      n_checks++; if (bus.rise !== 4'b0000) begin n_fail++; $display("FAIL gap_rise_early: got %b want 0000", bus.rise); end
      cycle(1'b1, smp(15, 0, 0, 0));
      if (bus.out_valid === 1'b1) ov_cnt++;
      n_checks++; if (bus.rise !== 4'b0001) begin n_fail++; $display("FAIL gap_rise_final: got %b want 0001", bus.rise); end
      n_checks++; if (ov_cnt != 3) begin n_fail++; $display("FAIL gap_out_valid: got %0d pulses want 3", ov_cnt); end
   endtask

   task automatic test_thr_load();
      do_reset();
      cycle(1'b0, smp(0, 0, 0, 0), 1'b1, 100, 200);
      n_checks++; if (bus.thr_hi !== 16'd100 || bus.thr_lo !== 16'd100) begin n_fail++; $display("FAIL load_clamp: got hi %0d lo %0d want 100 100", bus.thr_hi, bus.thr_lo); end
      do_reset();
      // ch1=11 fails the old thr_hi=12 but would pass the new thr_hi=5
      cycle(1'b1, smp(50, 11, 0, 0), 1'b1, 5, 2);
      n_checks++; if (bus.thr_hi !== 16'd5 || bus.thr_lo !== 16'd2) begin n_fail++; $display("FAIL load_values: got hi %0d lo %0d want 5 2", bus.thr_hi, bus.thr_lo); end
      cycle(1'b1, smp(50, 11, 0, 0));
      cycle(1'b1, smp(50, 11, 0, 0));
      n_checks++; if (bus.rise !== 4'b0001) begin n_fail++; $display("FAIL load_old_thr: got rise %b want 0001", bus.rise); end
      cycle(1'b1, smp(50, 11, 0, 0));
      n_checks++; if (bus.rise !== 4'b0010) begin n_fail++; $display("FAIL load_new_thr: got rise %b want 0010", bus.rise); end
   endtask

   task automatic test_reset_midrun();
      do_reset();
      cycle(1'b1, smp(15, 15, 0, 0));
      cycle(1'b1, smp(15, 15, 0, 0));
      reset_n = 1'b0;
      #1;
      n_checks++; if (bus.a_gteq_b !== 4'h0 || bus.fall !== 4'h0 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_state: got lvl %b fall %b ov %b", bus.a_gteq_b, bus.fall, bus.out_valid); end
      model_reset();
      @(posedge clock);
      #1 reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, smp(15, 15, 0, 0));
         n_checks++; if (bus.rise !== ((i == 2) ? 4'b0011 : 4'b0000)) begin n_fail++; $display("FAIL midrst_rise%0d: got %b", i, bus.rise); end
      end
   endtask

   task automatic test_random();
      int cur [CH];
      logic [CH*W-1:0] s;
      int hi, lo;
      logic ld, v;
      for (int k = 0; k < CH; k++) cur[k] = $urandom_range(0, 30);
      for (int n = 0; n < 600; n++) begin
         for (int k = 0; k < CH; k++) begin
            if ($urandom_range(0, 3) == 0) cur[k] = $urandom_range(0, 32);
            if ($urandom_range(0, 31) == 0) cur[k] = $urandom_range(0, 65535);
            s[k*W +: W] = W'(cur[k]);
         end
         v  = ($urandom_range(0, 3) != 0);
         ld = ($urandom_range(0, 15) == 0);
         hi = $urandom_range(0, 30);
         lo = $urandom_range(0, 30);
         if ($urandom_range(0, 7) == 0) hi = $urandom_range(0, 65535);
         cycle(v, s, ld, hi, lo);
         n_checks++; if (bus.a_gteq_b !== m_level() || bus.a_lt_b !== ~m_level()) begin n_fail++; $display("FAIL rnd_level@%0d: got %b/%b want %b", n, bus.a_gteq_b, bus.a_lt_b, m_level()); end
         n_checks++; if (bus.rise !== m_rise || bus.fall !== m_fall) begin n_fail++; $display("FAIL rnd_pulse@%0d: got r%b f%b want r%b f%b", n, bus.rise, bus.fall, m_rise, m_fall); end
         n_checks++; if (bus.out_valid !== m_ov) begin n_fail++; $display("FAIL rnd_ov@%0d: got %b want %b", n, bus.out_valid, m_ov); end
         n_checks++; if (bus.thr_hi !== W'(m_hi) || bus.thr_lo !== W'(m_lo)) begin n_fail++; $display("FAIL rnd_thr@%0d: got %0d/%0d want %0d/%0d", n, bus.thr_hi, bus.thr_lo, m_hi, m_lo); end
      end
   endtask

   initial begin
      bus.sample_valid = 1'b0;
      bus.sample       = '0;
      bus.thr_load     = 1'b0;
      bus.thr_hi_in    = '0;
      bus.thr_lo_in    = '0;
      model_reset();
      test_reset();
      test_persistence();
      test_hysteresis();
      do_reset();
      test_gaps();
      test_thr_load();
      test_reset_midrun();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
